// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   DATA_BITS   - number of payload bits per frame
//   tx_state_t  - serializer state encoding (IDLE, START, DATA, PARITY, STOP)
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock byte FIFO feeding the UART serializer. Storage is a plain
// array with a registered read port, so rd_data is valid the cycle after a
// pop. Writes while full and reads while empty are ignored.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (flushes pointers and count)
//   wr_en    - write strobe
//   wr_data  - write data
//   rd_en    - pop strobe
//   rd_data  - data of the most recently popped entry
//   full     - DEPTH entries held
//   empty    - no entries held
module uart_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE_C   = 1;
   localparam logic [AW:0] DEPTH_C = DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count_reg == DEPTH_C);
   assign empty   = (count_reg == '0);
   assign wr_ok   = wr_en & ~full;
   assign rd_ok   = rd_en & ~empty;
   assign rd_data = rd_data_reg;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + ONE_C;
            2'b01:   count_reg <= count_reg - ONE_C;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage and read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg] <= wr_data;
      if (rd_ok) rd_data_reg <= mem[rd_ptr_reg];
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// UART transmitter with a byte FIFO ahead of the serializer. Frames are
// start(0), 8 data bits LSB first, optional even parity, stop(1).
// Build option: define UART_TX_PARITY_EN to insert the even parity bit.
// Ports:
//   clk_i         - clock
//   rst_i         - asynchronous active-high reset
//   tx_dv_i       - write strobe, one byte per high cycle
//   tx_byte_i     - byte to enqueue
//   tx_full_o     - FIFO full
//   tx_empty_o    - FIFO empty
//   tx_overflow_o - one-cycle pulse when a write was dropped
//   tx_active_o   - frame on the line
//   tx_serial_o   - registered serial line, idle high
//   tx_done_o     - one-cycle pulse per completed frame
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tx_dv_i,
   input  logic [7:0] tx_byte_i,
   output logic       tx_full_o,
   output logic       tx_empty_o,
   output logic       tx_overflow_o,
   output logic       tx_active_o,
   output logic       tx_serial_o,
   output logic       tx_done_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST_C = BIT_W'(DATA_BITS - 1);

   tx_state_t            state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [BIT_W-1:0]     bit_reg, bit_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg, parity_next;
`endif
   logic                 serial_reg, serial_next;
   logic                 active_reg;
   logic                 stop_end_reg, stop_end_next;
   logic                 done_reg;
   logic                 overflow_reg;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [7:0]           fifo_rd_data;
   logic                 pop;
   logic                 bit_tick;

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (tx_dv_i),
      .wr_data (tx_byte_i),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bit_tick = (cnt_reg == CNT_LAST_C);

   // Next-state logic. serial_next describes the line level for the current
   // state; it is registered, so the line trails the state by one cycle.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bit_next      = bit_reg;
      shift_next    = shift_reg;
`ifdef UART_TX_PARITY_EN
      parity_next   = parity_reg;
`endif
      serial_next   = 1'b1;
      stop_end_next = 1'b0;
      pop           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_START;
            end
         end

         ST_START: begin
            serial_next = 1'b0;
            if (bit_tick) begin
               // Popped byte has been in the read register since START began.
               cnt_next   = '0;
               bit_next   = '0;
               shift_next = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
               parity_next = ^fifo_rd_data;
`endif
               state_next = ST_DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_DATA: begin
            serial_next = shift_reg[0];
            if (bit_tick) begin
               cnt_next   = '0;
               shift_next = shift_reg >> 1;
               if (bit_reg == BIT_LAST_C) begin
`ifdef UART_TX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
            serial_next = parity_reg;
            if (bit_tick) begin
               cnt_next   = '0;
               state_next = ST_STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`else
            state_next = ST_IDLE;
            cnt_next   = '0;
`endif
         end

         ST_STOP: begin
            serial_next = 1'b1;
            if (bit_tick) begin
               cnt_next      = '0;
               stop_end_next = 1'b1;
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
         serial_reg   <= 1'b1;
         active_reg   <= 1'b0;
         stop_end_reg <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= parity_next;
`endif
         serial_reg   <= serial_next;
         active_reg   <= (state_reg != ST_IDLE);
         // Stop period on the line ends one cycle after the state leaves
         // STOP; done fires in the cycle after that.
         stop_end_reg <= stop_end_next;
         done_reg     <= stop_end_reg;
         overflow_reg <= tx_dv_i & fifo_full;
      end
   end

   assign tx_serial_o   = serial_reg;
   assign tx_active_o   = active_reg;
   assign tx_done_o     = done_reg;
   assign tx_overflow_o = overflow_reg;
   assign tx_full_o     = fifo_full;
   assign tx_empty_o    = fifo_empty;

endmodule
